// File: rtl/logic_gate_bist.sv
// Registered WIDTH-bit two-operand logic unit with valid/ready handshake and a
// built-in self-test that sweeps every (a,b) pair through the real output register.
module logic_gate_bist #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  input  logic             bist_start,
  input  logic [2:0]       bist_op,
  input  logic             inject_fault,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_pass,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int VW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [VW-1:0]    r_vec;
  logic [2:0]       r_bop;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_gold;
  logic             r_vld;
  logic             r_cmp;
  logic             r_rdy_en;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERRW-1:0]  r_err;
  logic             w_start_acc;
  logic             w_push;
  logic [WIDTH-1:0] w_va;
  logic [WIDTH-1:0] w_vb;
  logic [WIDTH-1:0] w_flt;

  function automatic logic [WIDTH-1:0] f_logic(input logic [2:0] f_op,
                                               input logic [WIDTH-1:0] f_a,
                                               input logic [WIDTH-1:0] f_b);
    logic [WIDTH-1:0] res;
    case (f_op)
      3'd0:    res = f_a & f_b;
      3'd1:    res = f_a | f_b;
      3'd2:    res = f_a ^ f_b;
      3'd3:    res = ~(f_a & f_b);
      3'd4:    res = ~(f_a | f_b);
      3'd5:    res = ~(f_a ^ f_b);
      3'd6:    res = f_a & ~f_b;
      default: res = f_a;
    endcase
    return res;
  endfunction

  // Golden model: per-bit truth-table lookup indexed by {a[i],b[i]}, deliberately
  // structured differently from the datapath so a shared mistake is unlikely.
  function automatic logic [WIDTH-1:0] f_golden(input logic [2:0] g_op,
                                                input logic [WIDTH-1:0] g_a,
                                                input logic [WIDTH-1:0] g_b);
    logic [3:0]       tt;
    logic [WIDTH-1:0] res;
    res = '0;
    case (g_op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0100;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = tt[{g_a[i], g_b[i]}];
    end
    return res;
  endfunction

  assign w_va        = r_vec[WIDTH-1:0];
  assign w_vb        = r_vec[VW-1:WIDTH];
  assign w_flt       = WIDTH'(inject_fault);
  assign w_start_acc = (r_state == S_IDLE) & bist_start & ~r_vld;
  assign w_push      = in_valid & in_ready;

  // r_rdy_en is high only in IDLE, so the datapath is invisible while the BIST owns it
  assign in_ready  = r_rdy_en & (~r_vld | out_ready) & ~w_start_acc;
  assign out_valid = r_rdy_en & r_vld;
  assign y         = r_rdy_en ? r_y : '0;
  assign bist_busy = r_busy;
  assign bist_done = r_done;
  assign bist_pass = r_pass;
  assign err_cnt   = r_err;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_vec == {VW{1'b1}}) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shared output register: functional beats in IDLE, sweep vectors during RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y    <= '0;
      r_gold <= '0;
      r_vld  <= 1'b0;
      r_cmp  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmp <= 1'b0;
          if (w_push) begin
            r_y   <= f_logic(op, a, b) ^ w_flt;
            r_vld <= 1'b1;
          end else if (out_ready) begin
            r_vld <= 1'b0;
          end else begin
            r_vld <= r_vld;
          end
        end
        S_RUN: begin
          r_y    <= f_logic(r_bop, w_va, w_vb) ^ w_flt;
          r_gold <= f_golden(r_bop, w_va, w_vb);
          r_vld  <= 1'b0;
          r_cmp  <= 1'b1;
        end
        S_DRAIN: begin
          r_cmp <= 1'b0;
        end
        default: begin
          r_y   <= '0;
          r_vld <= 1'b0;
          r_cmp <= 1'b0;
        end
      endcase
    end
  end

  // BIST sequencing and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec    <= '0;
      r_bop    <= 3'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= (w_next == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_start_acc) begin
            r_vec  <= '0;
            r_bop  <= bist_op;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_vec != {VW{1'b1}}) begin
            r_vec <= r_vec + VW'(1);
          end
        end
        S_DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= (r_err == {ERRW{1'b0}});
        end
        default: begin
          r_busy <= r_busy;
        end
      endcase
    end
  end

  // Saturating mismatch counter; each compare checks the vector issued one cycle earlier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else if (w_start_acc) begin
      r_err <= '0;
    end else if (r_cmp && (r_y != r_gold) && (r_err != {ERRW{1'b1}})) begin
      r_err <= r_err + ERRW'(1);
    end
  end

endmodule

// File: tb/tb_logic_gate_bist.sv
// Table-driven bench for logic_gate_bist with a scoreboard on the functional path
// and hand-written sequences for backpressure, BIST runs and reset mid-run.
module tb_logic_gate_bist;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] a, b, y;
  logic [2:0] op, bist_op;
  logic       bist_start, inject_fault, bist_busy, bist_done, bist_pass;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;
  logic [3:0] cur_exp;
  logic [3:0] sb[$];

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       flt;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[11];

  logic_gate_bist #(.WIDTH(4), .ERRW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .bist_start(bist_start), .bist_op(bist_op), .inject_fault(inject_fault),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on a completed output handshake, push on an accepted beat
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() > 0) begin
          chk("sb_y", {28'd0, y}, {28'd0, sb.pop_front()});
        end else begin
          chk("sb_underflow", sb.size(), 1);
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic run_bist(input logic [2:0] bop, input logic flt, input int poke_at,
                          output int ncyc);
    bist_op = bop;
    inject_fault = flt;
    bist_start = 1'b1;
    cyc();
    bist_start = 1'b0;
    ncyc = 0;
    while (bist_busy && ncyc < 1000) begin
      bist_start = (ncyc == poke_at);
      if (ncyc == 100) begin
        chk("busy_in_ready", {31'd0, in_ready}, 0);
        chk("busy_out_valid", {31'd0, out_valid}, 0);
      end
      cyc();
      ncyc++;
    end
    bist_start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0]  = '{3'd0, 4'hC, 4'hA, 1'b0, 4'h8};
    tbl[1]  = '{3'd7, 4'hC, 4'hA, 1'b0, 4'hC};
    tbl[2]  = '{3'd3, 4'hC, 4'hA, 1'b0, 4'h7};
    tbl[3]  = '{3'd6, 4'hC, 4'hA, 1'b0, 4'h4};
    tbl[4]  = '{3'd1, 4'hC, 4'hA, 1'b0, 4'hE};
    tbl[5]  = '{3'd2, 4'hC, 4'hA, 1'b0, 4'h6};
    tbl[6]  = '{3'd4, 4'hC, 4'hA, 1'b0, 4'h1};
    tbl[7]  = '{3'd5, 4'hC, 4'hA, 1'b0, 4'h9};
    tbl[8]  = '{3'd0, 4'hF, 4'hF, 1'b0, 4'hF};
    tbl[9]  = '{3'd4, 4'h0, 4'h0, 1'b0, 4'hF};
    tbl[10] = '{3'd0, 4'hC, 4'hA, 1'b1, 4'h9};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 4'h0; b = 4'h0; op = 3'd0;
    bist_start = 1'b0; bist_op = 3'd0; inject_fault = 1'b0; cur_exp = 4'h0;
    #12;
    chk("reset_outputs", {15'd0, in_ready, out_valid, y, bist_busy, bist_done, bist_pass, err_cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
    chk("idle_in_ready", {31'd0, in_ready}, 1);

    // Latency: result visible exactly one cycle after acceptance
    op = 3'd0; a = 4'hC; b = 4'hA; cur_exp = 4'h8; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("lat1_valid", {31'd0, out_valid}, 1);
    chk("lat1_y", {28'd0, y}, 32'h8);
    cyc();
    chk("lat1_drop", {31'd0, out_valid}, 0);

    // Back-to-back table vectors
    for (int i = 0; i < 11; i++) begin
      op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
      inject_fault = tbl[i].flt; cur_exp = tbl[i].exp; in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0; inject_fault = 1'b0;
    cyc(); cyc();

    // Backpressure with two beats offered
    out_ready = 1'b0;
    op = 3'd1; a = 4'h3; b = 4'h5; cur_exp = 4'h7; in_valid = 1'b1;
    cyc();
    op = 3'd2; cur_exp = 4'h6;
    chk("bp_in_ready_low", {31'd0, in_ready}, 0);
    cyc(); cyc();
    chk("bp_hold_y", {28'd0, y}, 32'h7);
    chk("bp_hold_valid", {31'd0, out_valid}, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_pop", {31'd0, in_ready}, 1);
    cyc();
    in_valid = 1'b0;
    chk("bp_second_y", {28'd0, y}, 32'h6);
    cyc();
    chk("bp_empty", {31'd0, out_valid}, 0);

    // bist_start ignored while a result is pending
    out_ready = 1'b0;
    op = 3'd7; a = 4'h5; b = 4'h0; cur_exp = 4'h5; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    bist_start = 1'b1;
    cyc();
    bist_start = 1'b0;
    cyc();
    chk("ign_start_busy", {31'd0, bist_busy}, 0);
    chk("ign_start_valid", {31'd0, out_valid}, 1);
    chk("ign_start_y", {28'd0, y}, 32'h5);
    out_ready = 1'b1;
    cyc(); cyc();

    // Clean BIST with a start pulse poked mid-run
    run_bist(3'd2, 1'b0, 20, n);
    chk("bist_len", n, 258);
    chk("bist_done", {31'd0, bist_done}, 1);
    chk("bist_pass", {31'd0, bist_pass}, 1);
    chk("bist_err", {24'd0, err_cnt}, 0);
    chk("bist_clr_valid", {31'd0, out_valid}, 0);
    chk("bist_clr_y", {28'd0, y}, 0);

    // Fault injected for the whole run saturates the counter
    run_bist(3'd0, 1'b1, -1, n);
    inject_fault = 1'b0;
    chk("flt_len", n, 258);
    cyc(); cyc(); cyc();
    chk("flt_done_hold", {31'd0, bist_done}, 1);
    chk("flt_pass", {31'd0, bist_pass}, 0);
    chk("flt_err", {24'd0, err_cnt}, 32'hFF);

    // Functional path works after a BIST
    op = 3'd5; a = 4'h6; b = 4'h3; cur_exp = 4'hA; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("post_bist_y", {28'd0, y}, 32'hA);
    cyc();

    run_bist(3'd5, 1'b0, -1, n);
    chk("refix_len", n, 258);
    chk("refix_pass", {31'd0, bist_pass}, 1);
    chk("refix_err", {24'd0, err_cnt}, 0);

    // Asynchronous reset in the middle of RUN
    bist_op = 3'd3;
    bist_start = 1'b1;
    cyc();
    bist_start = 1'b0;
    repeat (50) cyc();
    chk("mid_busy", {31'd0, bist_busy}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {15'd0, in_ready, out_valid, y, bist_busy, bist_done, bist_pass, err_cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
    run_bist(3'd6, 1'b0, -1, n);
    chk("after_rst_len", n, 258);
    chk("after_rst_pass", {31'd0, bist_pass}, 1);
    chk("after_rst_err", {24'd0, err_cnt}, 0);

    cyc();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
